// File: rtl/rb_pkg.sv
// rb_pkg: owner encoding, lock limit, bus widths and the owner hand-off rule shared by the arbiter
package rb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        M0   = 2'd1,
        M1   = 2'd2
    } owner_t;

    localparam logic [3:0] LOCK_MAX = 4'd15;
    localparam int         ADDR_W   = 5;
    localparam int         DATA_W   = 8;

    // Next owner while a master holds the bank: release when it stops asking,
    // keep it while unopposed or while a lock is within budget, otherwise hand over.
    function automatic owner_t hold_next(
        input logic       own_req,
        input logic       oth_req,
        input logic       own_lock,
        input logic [3:0] cnt,
        input owner_t     cur,
        input owner_t     alt
    );
        return !own_req ? (oth_req ? alt : NONE) :
               (!oth_req || (own_lock && cnt != LOCK_MAX)) ? cur : alt;
    endfunction

endpackage

// File: rtl/rb_arbiter_if.sv
// rb_arbiter_if: two-master request/grant bus plus the single-port register-bank port
//   slave  : arbiter side (takes requests and RB_Q, drives grants, read returns, RB_RW/RB_A/RB_D)
//   master : environment side (masters and the bank)
interface rb_arbiter_if;
    import rb_pkg::*;

    logic              m0_req, m1_req;
    logic              m0_rw, m1_rw;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_lock, m1_lock;
    logic              m0_gnt, m1_gnt;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_rvalid, m1_rvalid;
    logic              RB_RW;
    logic [ADDR_W-1:0] RB_A;
    logic [DATA_W-1:0] RB_D;
    logic [DATA_W-1:0] RB_Q;

    modport slave (
        input  m0_req, m1_req, m0_rw, m1_rw, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_lock, m1_lock, RB_Q,
        output m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
               RB_RW, RB_A, RB_D
    );

    modport master (
        output m0_req, m1_req, m0_rw, m1_rw, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_lock, m1_lock, RB_Q,
        input  m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
               RB_RW, RB_A, RB_D
    );

endinterface

// File: rtl/rb_arbiter.sv
// rb_arbiter: two-master arbiter for a single-port 32x8 register bank
//   clk : clock, posedge
//   rst : asynchronous active-high reset
//   bus : rb_arbiter_if.slave -- master requests/grants/read returns and the bank port
module rb_arbiter
    import rb_pkg::*;
(
    input logic         clk,
    input logic         rst,
    rb_arbiter_if.slave bus
);

    owner_t     owner, owner_nxt, last_served;
    logic [3:0] lock_cnt;
    logic       gnt0, gnt1;

    // A grant is the owner asking this cycle; the access completes at the next edge.
    assign gnt0 = (owner == M0) && bus.m0_req;
    assign gnt1 = (owner == M1) && bus.m1_req;

    assign bus.m0_gnt = gnt0;
    assign bus.m1_gnt = gnt1;
    assign bus.RB_RW  = gnt0 ? bus.m0_rw    : gnt1 ? bus.m1_rw    : 1'b1;
    assign bus.RB_A   = gnt0 ? bus.m0_addr  : gnt1 ? bus.m1_addr  : '0;
    assign bus.RB_D   = gnt0 ? bus.m0_wdata : gnt1 ? bus.m1_wdata : '0;

    always_comb begin
        owner_nxt = NONE;
        case (owner)
            // Simultaneous requests from idle go to whoever was not served last.
            NONE:    owner_nxt = (bus.m0_req && bus.m1_req) ? ((last_served == M0) ? M1 : M0) :
                                 bus.m0_req ? M0 : bus.m1_req ? M1 : NONE;
            M0:      owner_nxt = hold_next(bus.m0_req, bus.m1_req, bus.m0_lock, lock_cnt, M0, M1);
            M1:      owner_nxt = hold_next(bus.m1_req, bus.m0_req, bus.m1_lock, lock_cnt, M1, M0);
            default: owner_nxt = NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= NONE;
            last_served <= M1;
            lock_cnt    <= 4'd0;
        end else begin
            owner       <= owner_nxt;
            lock_cnt    <= (owner_nxt != owner || owner_nxt == NONE) ? 4'd0 : lock_cnt + 4'(gnt0 | gnt1);
            last_served <= gnt0 ? M0 : gnt1 ? M1 : last_served;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m0_rvalid <= 1'b0;
            bus.m1_rvalid <= 1'b0;
            bus.m0_rdata  <= '0;
            bus.m1_rdata  <= '0;
        end else begin
            bus.m0_rvalid <= gnt0 && bus.m0_rw;
            bus.m1_rvalid <= gnt1 && bus.m1_rw;
            if (gnt0 && bus.m0_rw) bus.m0_rdata <= bus.RB_Q;
            if (gnt1 && bus.m1_rw) bus.m1_rdata <= bus.RB_Q;
        end
    end

endmodule

// File: tb/tb_rb_arbiter.sv
// tb_rb_arbiter: directed and randomized checks of rb_arbiter against a behavioural model
module tb_rb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rb_arbiter_if bus();
    rb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    logic       req[2], rw[2], lock[2];
    logic [4:0] addr[2];
    logic [7:0] wd[2];

    assign bus.m0_req   = req[0];
    assign bus.m1_req   = req[1];
    assign bus.m0_rw    = rw[0];
    assign bus.m1_rw    = rw[1];
    assign bus.m0_lock  = lock[0];
    assign bus.m1_lock  = lock[1];
    assign bus.m0_addr  = addr[0];
    assign bus.m1_addr  = addr[1];
    assign bus.m0_wdata = wd[0];
    assign bus.m1_wdata = wd[1];

    // Register bank: combinational read, write at the edge that ends a write access.
    logic [7:0] mem [32] = '{default: 8'h00};
    assign bus.RB_Q = mem[bus.RB_A];
    always @(posedge clk) if (!bus.RB_RW) mem[bus.RB_A] <= bus.RB_D;

    // Behavioural model: who is -1 (nobody) or the master index holding the bank.
    int         who, last, streak, gcur;
    logic [7:0] mmem [32];
    bit         e_gnt[2], e_rv[2];
    logic       e_rw;
    logic [4:0] e_a;
    logic [7:0] e_d;
    logic [7:0] e_rd[2];
    int         n_vec = 0, n_err = 0;

    function automatic logic [33:0] observed();
        return {bus.m0_gnt, bus.m1_gnt, bus.RB_RW, bus.RB_A, bus.RB_D,
                bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata};
    endfunction

    function automatic logic [33:0] expected();
        return {e_gnt[0], e_gnt[1], e_rw, e_a, e_d, e_rv[0], e_rv[1], e_rd[0], e_rd[1]};
    endfunction

    task automatic model_reset();
        who = -1; last = 1; streak = 0;
        e_rv[0] = 0; e_rv[1] = 0; e_rd[0] = 8'h00; e_rd[1] = 8'h00;
    endtask

    task automatic model_eval();
        gcur     = (who >= 0 && req[who] === 1'b1) ? who : -1;
        e_gnt[0] = (gcur == 0);
        e_gnt[1] = (gcur == 1);
        e_rw     = (gcur >= 0) ? rw[gcur]   : 1'b1;
        e_a      = (gcur >= 0) ? addr[gcur] : 5'd0;
        e_d      = (gcur >= 0) ? wd[gcur]   : 8'd0;
    endtask

    task automatic model_update();
        int nw, o;
        if (who < 0) nw = (req[0] && req[1]) ? 1 - last : req[0] ? 0 : req[1] ? 1 : -1;
        else begin
            o = 1 - who;
            if (!req[who]) nw = req[o] ? o : -1;
            else if (!req[o]) nw = who;
            else if (lock[who] && streak < 15) nw = who;
            else nw = o;
        end
        streak = (nw != who || nw < 0) ? 0 : (gcur >= 0) ? (streak + 1) % 16 : streak;
        e_rv[0] = 0;
        e_rv[1] = 0;
        if (gcur >= 0) begin
            if (rw[gcur]) begin
                e_rv[gcur] = 1;
                e_rd[gcur] = mmem[addr[gcur]];
            end else mmem[addr[gcur]] = wd[gcur];
            last = gcur;
        end
        who = nw;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        model_update();
        @(posedge clk);
        #2;
        model_eval();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        settle();
        n_vec++;
        if (observed() !== {1'b0, 1'b0, 1'b1, 5'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_state got %h want %h", observed(), {1'b0, 1'b0, 1'b1, 5'd0, 8'd0, 18'd0});
        end
        rst = 1'b0;
    endtask

    task automatic test_read_alone();
        req[0] = 1; rw[0] = 0; addr[0] = 5'd5; wd[0] = 8'hA3;
        settle();
        n_vec++;
        if (bus.m0_gnt !== 1'b0) begin n_err++; $display("FAIL wr_idle_gnt got %b want 0", bus.m0_gnt); end
        tick();
        n_vec++;
        if ({bus.m0_gnt, bus.RB_RW, bus.RB_A, bus.RB_D} !== {1'b1, 1'b0, 5'd5, 8'hA3}) begin
            n_err++;
            $display("FAIL wr_grant got %b %b %0d %h want 1 0 5 a3", bus.m0_gnt, bus.RB_RW, bus.RB_A, bus.RB_D);
        end
        tick();
        req[0] = 0;
        settle();
        tick();
        req[0] = 1; rw[0] = 1;
        settle();
        n_vec++;
        if (bus.m0_gnt !== 1'b0) begin n_err++; $display("FAIL rd_idle_gnt got %b want 0", bus.m0_gnt); end
        tick();
        n_vec++;
        if ({bus.m0_gnt, bus.RB_RW, bus.RB_A, bus.m0_rvalid} !== {1'b1, 1'b1, 5'd5, 1'b0}) begin
            n_err++;
            $display("FAIL rd_grant got %b %b %0d %b want 1 1 5 0", bus.m0_gnt, bus.RB_RW, bus.RB_A, bus.m0_rvalid);
        end
        tick();
        req[0] = 0;
        settle();
        n_vec++;
        if ({bus.m0_rvalid, bus.m0_rdata} !== {1'b1, 8'hA3}) begin
            n_err++;
            $display("FAIL rd_return got %b %h want 1 a3", bus.m0_rvalid, bus.m0_rdata);
        end
        tick();
        n_vec++;
        if ({bus.m0_rvalid, bus.m0_rdata} !== {1'b0, 8'hA3}) begin
            n_err++;
            $display("FAIL rd_pulse got %b %h want 0 a3", bus.m0_rvalid, bus.m0_rdata);
        end
    endtask

    task automatic test_alternation();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        req[0] = 1; req[1] = 1; rw[0] = 1; rw[1] = 1; lock[0] = 0; lock[1] = 0;
        addr[0] = 5'd5; addr[1] = 5'd9;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({bus.m0_gnt, bus.m1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01) || observed() !== expected()) begin
                n_err++;
                $display("FAIL alternate[%0d] got %h want %h", k, observed(), expected());
            end
            tick();
        end
        req[0] = 0; req[1] = 0;
        tick();
        tick();
    endtask

    task automatic test_lock();
        int n1 = 0;
        bit seen0 = 0;
        req[0] = 1; rw[0] = 0; addr[0] = 5'd3; wd[0] = 8'h11;
        tick();
        tick();
        req[0] = 0;
        tick();
        req[0] = 1; req[1] = 1; rw[0] = 1; rw[1] = 1; lock[1] = 1; addr[1] = 5'd17;
        tick();
        for (int i = 0; i < 40 && !seen0; i++) begin
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL lock_cycle[%0d] got %h want %h", i, observed(), expected());
            end
            if (bus.m0_gnt) seen0 = 1;
            else if (bus.m1_gnt) n1++;
            tick();
        end
        n_vec++;
        if (n1 != 16 || !seen0) begin
            n_err++;
            $display("FAIL lock_run got %0d m1 grants then m0=%b want 16 then 1", n1, seen0);
        end
        req[0] = 0; req[1] = 0; lock[1] = 0;
        tick();
        tick();
    endtask

    task automatic test_write_read();
        int nw0 = 0;
        req[0] = 1; rw[0] = 0; addr[0] = 5'd17; wd[0] = 8'h5C;
        tick();
        nw0 += (bus.RB_RW == 1'b0);
        n_vec++;
        if ({bus.m0_gnt, bus.RB_RW, bus.RB_A, bus.RB_D} !== {1'b1, 1'b0, 5'd17, 8'h5C}) begin
            n_err++;
            $display("FAIL wr17 got %b %b %0d %h want 1 0 17 5c", bus.m0_gnt, bus.RB_RW, bus.RB_A, bus.RB_D);
        end
        tick();
        req[0] = 0; req[1] = 1; rw[1] = 1; addr[1] = 5'd17;
        settle();
        nw0 += (bus.RB_RW == 1'b0);
        n_vec++;
        if ({bus.m1_gnt, bus.m0_rvalid, bus.RB_RW} !== 3'b001) begin
            n_err++;
            $display("FAIL wr17_after got gnt1=%b rv0=%b rw=%b want 0 0 1", bus.m1_gnt, bus.m0_rvalid, bus.RB_RW);
        end
        tick();
        nw0 += (bus.RB_RW == 1'b0);
        n_vec++;
        if ({bus.m1_gnt, bus.RB_RW, bus.RB_A} !== {1'b1, 1'b1, 5'd17}) begin
            n_err++;
            $display("FAIL rd17_grant got %b %b %0d want 1 1 17", bus.m1_gnt, bus.RB_RW, bus.RB_A);
        end
        tick();
        req[1] = 0;
        settle();
        nw0 += (bus.RB_RW == 1'b0);
        n_vec++;
        if ({bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid} !== {1'b1, 8'h5C, 1'b0}) begin
            n_err++;
            $display("FAIL rd17_return got %b %h rv0=%b want 1 5c 0", bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid);
        end
        n_vec++;
        if (nw0 != 1) begin n_err++; $display("FAIL wr17_cycles got %0d want 1", nw0); end
        tick();
    endtask

    task automatic test_reset_mid();
        req[0] = 1; req[1] = 1; rw[0] = 1; rw[1] = 1; addr[0] = 5'd5; addr[1] = 5'd17;
        tick();
        n_vec++;
        if (bus.m0_gnt !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got %b want 1", bus.m0_gnt); end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.RB_RW, bus.RB_A} !== {4'b0000, 1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL rstmid_now got %b%b%b%b %b %0d want 0000 1 0", bus.m0_gnt, bus.m1_gnt,
                     bus.m0_rvalid, bus.m1_rvalid, bus.RB_RW, bus.RB_A);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        settle();
        n_vec++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_release got %b%b%b want 000", bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid);
        end
        tick();
        n_vec++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid} !== 3'b100) begin
            n_err++;
            $display("FAIL rstmid_first got %b%b%b want 100", bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid);
        end
        req[0] = 0; req[1] = 0;
        tick();
        tick();
    endtask

    task automatic test_cancel();
        int g1 = 0;
        req[0] = 1; rw[0] = 1; lock[0] = 1; addr[0] = 5'd17;
        tick();
        req[1] = 1; rw[1] = 1; addr[1] = 5'd5;
        settle();
        g1 += bus.m1_gnt + bus.m1_rvalid;
        tick();
        g1 += bus.m1_gnt + bus.m1_rvalid;
        req[1] = 0;
        settle();
        tick();
        g1 += bus.m1_gnt + bus.m1_rvalid;
        req[0] = 0;
        settle();
        tick();
        g1 += bus.m1_gnt + bus.m1_rvalid;
        n_vec++;
        if (g1 != 0) begin n_err++; $display("FAIL cancel_m1 got %0d m1 events want 0", g1); end
        req[0] = 1;
        settle();
        n_vec++;
        if (bus.m0_gnt !== 1'b0) begin n_err++; $display("FAIL cancel_idle got gnt0=%b want 0", bus.m0_gnt); end
        tick();
        n_vec++;
        if (bus.m0_gnt !== 1'b1) begin n_err++; $display("FAIL cancel_regrant got gnt0=%b want 1", bus.m0_gnt); end
        req[0] = 0; lock[0] = 0;
        tick();
        tick();
    endtask

    task automatic test_random();
        bit gprev[2] = '{0, 0};
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (req[i] && !gprev[i]) begin
                    if ($urandom_range(0, 7) == 0) req[i] = 0;
                end else begin
                    req[i]  = $urandom_range(0, 3) != 0;
                    rw[i]   = 1'($urandom_range(0, 1));
                    addr[i] = 5'($urandom_range(0, 31));
                    wd[i]   = 8'($urandom);
                end
                lock[i] = $urandom_range(0, 3) != 0;
            end
            settle();
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL random[%0d] got %h want %h", c, observed(), expected());
            end
            gprev[0] = e_gnt[0];
            gprev[1] = e_gnt[1];
            tick();
        end
        req[0] = 0; req[1] = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; rw[i] = 1; lock[i] = 0; addr[i] = 5'd0; wd[i] = 8'd0;
        end
        for (int i = 0; i < 32; i++) mmem[i] = 8'h00;
        model_reset();
        test_reset();
        test_read_alone();
        test_alternation();
        test_lock();
        test_write_read();
        test_reset_mid();
        test_cancel();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rb_arbiter.md
RB_ARBITER -- requirements
Module: rb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, clock; all sequential logic on posedge.
REQ-002 SHALL have port rst, input, 1; reset rst, asynchronous, active-high.
REQ-003 SHALL have ports m0_req, m1_req, input, 1 each, access request from master 0 or 1.
REQ-004 SHALL have ports m0_rw, m1_rw, input, 1 each; 1 = read, 0 = write.
REQ-005 SHALL have ports m0_addr, m1_addr, input, 5 each, bank address.
REQ-006 SHALL have ports m0_wdata, m1_wdata, input, 8 each, write data.
REQ-007 SHALL have ports m0_lock, m1_lock, input, 1 each; request to hold the grant across accesses.
REQ-008 SHALL have ports m0_gnt, m1_gnt, output, 1 each; the access is performed in this cycle.
REQ-009 SHALL have ports m0_rdata, m1_rdata, output, 8 each, and m0_rvalid, m1_rvalid, output, 1 each.
REQ-010 SHALL have ports RB_RW (output, 1), RB_A (output, 5), RB_D (output, 8) and RB_Q (input, 8), connected to the single-port 32x8 register bank; RB_Q is combinational from RB_A.

Function
REQ-011 SHALL keep owner state in {NONE, M0, M1}, registered.
REQ-012 SHALL compute mX_gnt = (owner==MX) && mX_req, combinationally.
REQ-013 SHALL treat each cycle with mX_gnt=1 as exactly one access.
REQ-014 SHALL, when m0_gnt=1 or m1_gnt=1, drive RB_RW/RB_A/RB_D combinationally from that master; otherwise RB_RW=1, RB_A=0, RB_D=0.
REQ-015 SHALL register RB_Q into mX_rdata and pulse mX_rvalid for exactly 1 cycle, 1 cycle after a granted read.
REQ-016 SHALL hold mX_rdata until the next granted read by that master, and SHALL NOT raise rvalid for writes.
REQ-017 SHALL, from NONE, move to the requesting master.
REQ-018 SHALL, from NONE with both requesting, pick the master not equal to last_served; last_served resets to M1, so M0 wins first.
REQ-019 SHALL, in MX with mX_req=0, move to the other master if it is requesting, else to NONE.
REQ-020 SHALL, in MX with mX_req=1 and the other master idle, stay in MX.
REQ-021 SHALL, in MX with both requesting and mX_lock=0, switch to the other master after the current access (alternation per access).
REQ-022 SHALL, in MX with both requesting and mX_lock=1, stay in MX while lock_cnt<15.
REQ-023 SHALL force a switch when lock_cnt==15 (at most 16 consecutive locked accesses while the other master waits).
REQ-024 SHALL increment lock_cnt (4 bits) on each granted access while the owner is unchanged, and clear it on any owner change or on entry to NONE.
REQ-025 SHALL update last_served to MX on every granted access by MX.
REQ-026 SHALL require masters to hold req/rw/addr/wdata stable until gnt; dropping req before gnt cancels with no bank access.
REQ-027 SHALL never assert m0_gnt and m1_gnt in the same cycle.

Reset
REQ-028 SHALL, on rst, immediately set owner=NONE, last_served=M1, lock_cnt=0, m0_gnt=m1_gnt=0, mX_rvalid=0, mX_rdata=0, RB_RW=1, RB_A=0, RB_D=0.
REQ-029 SHALL, on rst asserted mid-access, abandon the access with no rvalid afterward; masters re-request after reset.
REQ-030 SHALL, after rst deassertion, grant at the earliest 1 cycle after the first sampled req.

Structure
REQ-031 SHALL take the owner encoding (NONE=2'd0, M0=2'd1, M1=2'd2), LOCK_MAX=4'd15, ADDR_W=5 and DATA_W=8 from shared package rb_pkg.
REQ-032 SHALL be a single module with no sub-modules; one owner FSM and one read-return register pair per master.

Verification
REQ-033 SHALL cover: m0 read addr 5 alone (bank[5]=8'hA3) -> m0_gnt 1 cycle after req, RB_A=5, RB_RW=1, m0_rvalid next cycle with m0_rdata=8'hA3.
REQ-034 SHALL cover: both request in the same cycle after reset, lock=0 -> gnt order m0,m1,m0,m1 on consecutive cycles.
REQ-035 SHALL cover: m1 holds lock=1 with m0 requesting -> exactly 16 consecutive m1_gnt, then m0_gnt.
REQ-036 SHALL cover: m0 write addr 17 data 8'h5C, then m1 read addr 17 -> RB_RW=0 for one cycle, then m1_rdata=8'h5C, no m0_rvalid.
REQ-037 SHALL cover: rst pulsed while m0_gnt=1 -> gnt and rvalid low immediately, RB_RW=1, RB_A=0, and the first grant after release goes to m0.
REQ-038 SHALL cover: m1 drops req before gnt while m0 owns -> no m1 access, and owner goes to NONE when m0 finishes.
